// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and types for the register-file access controller.
// Optional feature macro: REGFILE_X0_ZERO_EN (register 0 hardwired to zero).
package regfile_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  // Response holding state: nothing held, or a read result waiting for decode.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: picks at most one register-file operation per cycle.
// Writeback has priority; a saturating starvation counter forces a read
// through after STARVE_LIMIT consecutive lost arbitrations. A dropped write
// (i_wb_drop, used for x0 when REGFILE_X0_ZERO_EN is defined) is accepted
// without consuming the register-file slot.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rd_req_valid,
  input  logic i_rd_eligible,
  input  logic i_wb_valid,
  input  logic i_wb_drop,
  output logic o_grant_rd_c,
  output logic o_grant_wr_c,
  output logic o_wb_ready_c
);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_rd_want;
  logic                    w_starved;

  assign w_rd_want = i_rd_req_valid && i_rd_eligible;
  assign w_starved = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  // Priority select; everything is held off while reset is asserted.
  always_comb begin
    o_grant_rd_c = 1'b0;
    o_grant_wr_c = 1'b0;
    o_wb_ready_c = 1'b0;
    if (!i_reset) begin
      if (i_wb_valid && i_wb_drop) begin
        o_wb_ready_c = 1'b1;
        o_grant_rd_c = w_rd_want;
      end else if (w_rd_want && w_starved) begin
        o_grant_rd_c = 1'b1;
      end else if (i_wb_valid) begin
        o_grant_wr_c = 1'b1;
        o_wb_ready_c = 1'b1;
      end else begin
        o_grant_rd_c = w_rd_want;
      end
    end
  end

  // Count consecutive cycles an eligible read lost to a write; saturates at the limit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (!i_rd_req_valid || o_grant_rd_c) begin
      r_starve_cnt <= '0;
    end else if (w_rd_want && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitration and sequencing for the single-port 32x32
// register file shared by the operand-read port and the writeback port.
// Holds each read result with a valid/ready handshake until decode takes it.
// Optional feature macro: REGFILE_X0_ZERO_EN (x0 writes dropped, x0 reads zero).
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  // operand-read request
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [REG_IDX_W-1:0] rd_rs1,
  input  logic [REG_IDX_W-1:0] rd_rs2,
  // operand-read response
  output logic                 rd_rsp_valid,
  input  logic                 rd_rsp_ready,
  output logic [DATA_W-1:0]    rd_rsp_a,
  output logic [DATA_W-1:0]    rd_rsp_b,
  // writeback
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  // register-file port
  output logic                 rf_enable,
  output logic                 rf_read_write,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [REG_IDX_W-1:0] rf_rs1,
  output logic [REG_IDX_W-1:0] rf_rs2,
  output logic [DATA_W-1:0]    rf_din,
  input  logic [DATA_W-1:0]    rf_a,
  input  logic [DATA_W-1:0]    rf_b
);

  rsp_state_e r_rsp_state;
  rsp_state_e w_rsp_state_nxt;
  logic       w_rd_eligible;
  logic       w_wb_drop;
  logic       w_grant_rd;
  logic       w_grant_wr;
  logic       w_wb_ready;

  // A new read may start when nothing is held or the held result leaves this cycle.
  assign w_rd_eligible = (r_rsp_state == IDLE) || rd_rsp_ready;

`ifdef REGFILE_X0_ZERO_EN
  assign w_wb_drop = (wb_rd == REG_IDX_W'(0));
`else
  assign w_wb_drop = 1'b0;
`endif

  regfile_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arbiter (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_rd_req_valid (rd_req_valid),
    .i_rd_eligible  (w_rd_eligible),
    .i_wb_valid     (wb_valid),
    .i_wb_drop      (w_wb_drop),
    .o_grant_rd_c   (w_grant_rd),
    .o_grant_wr_c   (w_grant_wr),
    .o_wb_ready_c   (w_wb_ready)
  );

  assign rd_req_ready = w_grant_rd;
  assign wb_ready     = w_wb_ready;

  // Response FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_state <= IDLE;
    end else begin
      r_rsp_state <= w_rsp_state_nxt;
    end
  end

  // Response FSM next state: a read grant always (re)loads the response.
  always_comb begin
    w_rsp_state_nxt = r_rsp_state;
    case (r_rsp_state)
      IDLE: begin
        if (w_grant_rd) begin
          w_rsp_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_grant_rd) begin
          w_rsp_state_nxt = RESP;
        end else if (rd_rsp_ready) begin
          w_rsp_state_nxt = IDLE;
        end
      end
      default: w_rsp_state_nxt = IDLE;
    endcase
  end

  // Response FSM output: valid only while a result is held and not in reset.
  always_comb begin
    rd_rsp_valid = 1'b0;
    if (!reset && (r_rsp_state == RESP)) begin
      rd_rsp_valid = 1'b1;
    end
  end

`ifdef REGFILE_X0_ZERO_EN
  logic r_zero_a;
  logic r_zero_b;

  // Remember which operands named x0 so their data can be forced to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_zero_a <= 1'b0;
      r_zero_b <= 1'b0;
    end else if (w_grant_rd) begin
      r_zero_a <= (rd_rs1 == REG_IDX_W'(0));
      r_zero_b <= (rd_rs2 == REG_IDX_W'(0));
    end
  end

  // Operand data with x0 masking applied while the response is held.
  always_comb begin
    rd_rsp_a = rf_a;
    rd_rsp_b = rf_b;
    if (r_rsp_state == RESP) begin
      if (r_zero_a) begin
        rd_rsp_a = '0;
      end
      if (r_zero_b) begin
        rd_rsp_b = '0;
      end
    end
  end
`else
  // Operand data passes straight through from the register file.
  always_comb begin
    rd_rsp_a = rf_a;
    rd_rsp_b = rf_b;
  end
`endif

  // Register-file port mux: indices and data pass through, enable follows the grant.
  always_comb begin
    rf_enable     = w_grant_rd || w_grant_wr;
    rf_read_write = w_grant_wr;
    rf_rd         = wb_rd;
    rf_din        = wb_data;
    rf_rs1        = rd_rs1;
    rf_rs2        = rd_rs2;
  end

endmodule
